// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO block: synchronized and debounced KEY/SW inputs, sticky key-press flags,
// a prescaled free-running timer and three display registers behind a 16-bit register window.
module io_bus_ctrl #(
    parameter int DBITS       = 16,
    parameter int DEB_CYCLES  = 50000,
    parameter int TICK_CYCLES = 50000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] WDATA,
    input  logic             WE,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [DBITS-1:0] RDATA,
    output logic             IOSEL,
    output logic [DBITS-1:0] HEXOUT,
    output logic [9:0]       LEDROUT,
    output logic [7:0]       LEDGOUT
);

    localparam int NIN = 14;
    localparam logic [NIN-1:0] IN_RST = {10'b0, 4'hF};
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int PCW = $clog2(TICK_CYCLES + 1);

    localparam logic [DBITS-1:0] A_KEY   = {{(DBITS-4){1'b1}}, 4'h0};
    localparam logic [DBITS-1:0] A_SW    = {{(DBITS-4){1'b1}}, 4'h2};
    localparam logic [DBITS-1:0] A_KFLAG = {{(DBITS-4){1'b1}}, 4'h4};
    localparam logic [DBITS-1:0] A_TCNT  = {{(DBITS-4){1'b1}}, 4'h6};
    localparam logic [DBITS-1:0] A_HEX   = {{(DBITS-4){1'b1}}, 4'h8};
    localparam logic [DBITS-1:0] A_LEDR  = {{(DBITS-4){1'b1}}, 4'hA};
    localparam logic [DBITS-1:0] A_LEDG  = {{(DBITS-4){1'b1}}, 4'hC};

    // KEY occupies bits [3:0], SW bits [13:4] of every input-path vector
    logic [NIN-1:0] sync_p0, sync_p1, acc, acc_nxt;
    logic [DCW-1:0] deb_cnt [NIN];
    logic [DCW-1:0] cnt_nxt [NIN];
    logic [PCW-1:0] presc;
    logic [DBITS-1:0] tcnt;
    logic [3:0] kflag, press, kclr;
    logic wr_kflag, wr_tcnt, wr_hex, wr_ledr, wr_ledg;

    // Stage p0/p1: two-flop synchronizer for the asynchronous inputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_p0 <= IN_RST;
            sync_p1 <= IN_RST;
        end else begin
            sync_p0 <= {SW, KEY};
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < NIN; i++) begin
            cnt_nxt[i] = '0;
            if (sync_p1[i] != acc[i]) begin
                if (deb_cnt[i] == DCW'(DEB_CYCLES - 1))
                    acc_nxt[i] = sync_p1[i];
                else
                    cnt_nxt[i] = deb_cnt[i] + DCW'(1);
            end
        end
    end

    // Keys are active-low, so a press is an accepted 1->0 transition
    assign press = acc[3:0] & ~acc_nxt[3:0];

    assign wr_kflag = WE && (ADDR == A_KFLAG);
    assign wr_tcnt  = WE && (ADDR == A_TCNT);
    assign wr_hex   = WE && (ADDR == A_HEX);
    assign wr_ledr  = WE && (ADDR == A_LEDR);
    assign wr_ledg  = WE && (ADDR == A_LEDG);
    assign kclr     = wr_kflag ? WDATA[3:0] : 4'h0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc     <= IN_RST;
            for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
            kflag   <= '0;
            presc   <= '0;
            tcnt    <= '0;
            HEXOUT  <= '0;
            LEDROUT <= '0;
            LEDGOUT <= '0;
        end else begin
            acc     <= acc_nxt;
            deb_cnt <= cnt_nxt;
            // A press landing on the same edge as its clear wins
            kflag   <= (kflag & ~kclr) | press;
            if (wr_tcnt) begin
                tcnt  <= WDATA;
                presc <= '0;
            end else if (presc == PCW'(TICK_CYCLES - 1)) begin
                tcnt  <= tcnt + DBITS'(1);
                presc <= '0;
            end else begin
                presc <= presc + PCW'(1);
            end
            if (wr_hex)  HEXOUT  <= WDATA;
            if (wr_ledr) LEDROUT <= WDATA[9:0];
            if (wr_ledg) LEDGOUT <= WDATA[7:0];
        end
    end

    assign IOSEL = (ADDR[DBITS-1:4] == '1);

    // Reads during reset present the reset values, not the stale register contents
    always_comb begin
        RDATA = DBITS'(16'hDEAD);
        case (ADDR)
            A_KEY:   RDATA = RESET ? DBITS'(4'hF) : DBITS'(acc[3:0]);
            A_SW:    RDATA = RESET ? '0 : DBITS'(acc[13:4]);
            A_KFLAG: RDATA = RESET ? '0 : DBITS'(kflag);
            A_TCNT:  RDATA = RESET ? '0 : tcnt;
            A_HEX:   RDATA = RESET ? '0 : HEXOUT;
            A_LEDR:  RDATA = RESET ? '0 : DBITS'(LEDROUT);
            A_LEDG:  RDATA = RESET ? '0 : DBITS'(LEDGOUT);
            default: RDATA = DBITS'(16'hDEAD);
        endcase
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: directed scenarios followed by random traffic, all checked
// against a cycle-indexed behavioural model of the register map.
module tb_io_bus_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 3;
    localparam int MAXC = 8192;
    localparam logic [13:0] RV = {10'b0, 4'hF};

    logic        CLK = 1'b0;
    logic        RESET, WE, IOSEL;
    logic [15:0] ADDR, WDATA, RDATA, HEXOUT;
    logic [3:0]  KEY;
    logic [9:0]  SW, LEDROUT;
    logic [7:0]  LEDGOUT;

    int vectors = 0;
    int miscompares = 0;

    io_bus_ctrl #(.DBITS(16), .DEB_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA), .WE(WE),
        .KEY(KEY), .SW(SW), .RDATA(RDATA), .IOSEL(IOSEL),
        .HEXOUT(HEXOUT), .LEDROUT(LEDROUT), .LEDGOUT(LEDGOUT)
    );

    always #5 CLK = ~CLK;

    // Model state: s_hist[t] is the synchronized input vector visible after edge t
    int          t = 0;
    logic [13:0] s_hist [MAXC];
    logic [13:0] m_p0 = RV;
    logic [13:0] m_acc = RV;
    int          last_ev [14];
    logic [3:0]  m_kflag = '0;
    logic [15:0] m_tbase = '0;
    int          m_tload = 0;
    logic [15:0] m_hex = '0;
    logic [9:0]  m_ledr = '0;
    logic [7:0]  m_ledg = '0;

    function automatic logic [15:0] m_tcnt();
        logic [31:0] v;
        v = 32'(m_tbase) + 32'((t - m_tload) / TICK);
        return v[15:0];
    endfunction

    function automatic logic [15:0] exp_rdata(input logic [15:0] a);
        if (RESET) begin
            if (a == 16'hFFF0) return 16'h000F;
            if (a inside {16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC}) return 16'h0000;
            return 16'hDEAD;
        end
        case (a)
            16'hFFF0: return {12'b0, m_acc[3:0]};
            16'hFFF2: return {6'b0, m_acc[13:4]};
            16'hFFF4: return {12'b0, m_kflag};
            16'hFFF6: return m_tcnt();
            16'hFFF8: return m_hex;
            16'hFFFA: return {6'b0, m_ledr};
            16'hFFFC: return {8'b0, m_ledg};
            default:  return 16'hDEAD;
        endcase
    endfunction

    // Apply the rules for one rising edge using the inputs presented during that cycle
    task automatic model_edge();
        logic [3:0] press, clr;
        bit ok;
        t++;
        press = '0;
        clr = '0;
        if (RESET) begin
            s_hist[t] = RV;
            m_p0 = RV;
            m_acc = RV;
            for (int b = 0; b < 14; b++) last_ev[b] = t;
            m_kflag = '0;
            m_tbase = '0;
            m_tload = t;
            m_hex = '0;
            m_ledr = '0;
            m_ledg = '0;
        end else begin
            s_hist[t] = m_p0;
            m_p0 = {SW, KEY};
            // A bit is accepted once the last DEB samples since the previous event all disagree
            for (int b = 0; b < 14; b++) begin
                if (t - last_ev[b] >= DEB) begin
                    ok = 1'b1;
                    for (int k = t - DEB; k < t; k++)
                        if (s_hist[k][b] == m_acc[b]) ok = 1'b0;
                    if (ok) begin
                        m_acc[b] = ~m_acc[b];
                        last_ev[b] = t;
                        if (b < 4 && m_acc[b] == 1'b0) press[b] = 1'b1;
                    end
                end
            end
            if (WE) begin
                case (ADDR)
                    16'hFFF4: clr = WDATA[3:0];
                    16'hFFF6: begin m_tbase = WDATA; m_tload = t; end
                    16'hFFF8: m_hex = WDATA;
                    16'hFFFA: m_ledr = WDATA[9:0];
                    16'hFFFC: m_ledg = WDATA[7:0];
                    default: ;
                endcase
            end
            m_kflag = (m_kflag & ~clr) | press;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        check("rdata", 32'(RDATA), 32'(exp_rdata(ADDR)));
        check("iosel", 32'(IOSEL), 32'(ADDR[15:4] == 12'hFFF));
        check("hexout", 32'(HEXOUT), 32'(m_hex));
        check("ledrout", 32'(LEDROUT), 32'(m_ledr));
        check("ledgout", 32'(LEDGOUT), 32'(m_ledg));
    endtask

    task automatic peek(input logic [15:0] a, input logic [15:0] exp, input string tag);
        ADDR = a;
        WE = 1'b0;
        #1;
        check(tag, 32'(RDATA), 32'(exp));
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        WDATA = d;
        WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    logic [15:0] addr_tbl [10];

    initial begin
        addr_tbl = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8,
                     16'hFFFA, 16'hFFFC, 16'hFFFE, 16'h0100, 16'hFFF1};
        s_hist[0] = RV;
        for (int b = 0; b < 14; b++) last_ev[b] = 0;
        RESET = 1'b1; WE = 1'b0; ADDR = 16'hFFF0; WDATA = '0; KEY = 4'hF; SW = '0;

        // Reset values
        repeat (2) cyc();
        peek(16'hFFF0, 16'h000F, "rst_key");
        peek(16'hFFF6, 16'h0000, "rst_tcnt");
        peek(16'hFFF4, 16'h0000, "rst_kflag");
        RESET = 1'b0;
        cyc();
        peek(16'hFFF2, 16'h0000, "rst_sw");
        peek(16'hFFF8, 16'h0000, "rst_hex");

        // Press KEY[1]: accepted exactly 2+DEB cycles later, glitch ignored
        ADDR = 16'hFFF0; KEY = 4'b1101;
        repeat (5) cyc();
        peek(16'hFFF0, 16'h000F, "key_before_lat");
        cyc();
        peek(16'hFFF0, 16'h000D, "key_accepted");
        peek(16'hFFF4, 16'h0002, "kflag_set");
        KEY = 4'hF;
        repeat (6) cyc();
        peek(16'hFFF0, 16'h000F, "key_release");
        KEY = 4'b1011;
        repeat (3) cyc();
        KEY = 4'hF;
        repeat (8) cyc();
        peek(16'hFFF0, 16'h000F, "glitch_key");
        peek(16'hFFF4, 16'h0002, "glitch_kflag");
        store(16'hFFF4, 16'h0002);
        peek(16'hFFF4, 16'h0000, "kflag_w1c");

        // Clear coinciding with a fresh press keeps the flag; a plain clear drops it
        KEY = 4'b1101; ADDR = 16'hFFF4;
        repeat (5) cyc();
        store(16'hFFF4, 16'h0002);
        peek(16'hFFF4, 16'h0002, "w1c_set_prio");
        peek(16'hFFF0, 16'h000D, "key_again");
        store(16'hFFF4, 16'h0002);
        peek(16'hFFF4, 16'h0000, "w1c_plain");
        KEY = 4'hF;
        repeat (6) cyc();

        // Timer load and wrap of TCNT
        store(16'hFFF6, 16'hFFFE);
        peek(16'hFFF6, 16'hFFFE, "tcnt_load");
        repeat (2) cyc();
        peek(16'hFFF6, 16'hFFFE, "tcnt_hold");
        cyc();
        peek(16'hFFF6, 16'hFFFF, "tcnt_ffff");
        repeat (3) cyc();
        peek(16'hFFF6, 16'h0000, "tcnt_wrap");
        repeat (2) cyc();
        store(16'hFFF6, 16'h0100);
        peek(16'hFFF6, 16'h0100, "tcnt_wr_prio");
        repeat (2) cyc();
        peek(16'hFFF6, 16'h0100, "tcnt_presc_clr");
        cyc();
        peek(16'hFFF6, 16'h0101, "tcnt_tick");

        // Display registers and width truncation
        store(16'hFFF8, 16'h1234);
        store(16'hFFFA, 16'hFFFF);
        store(16'hFFFC, 16'hABCD);
        check("hexout_val", 32'(HEXOUT), 32'h1234);
        check("ledr_val", 32'(LEDROUT), 32'h3FF);
        check("ledg_val", 32'(LEDGOUT), 32'hCD);
        peek(16'hFFF8, 16'h1234, "hex_rd");
        peek(16'hFFFA, 16'h03FF, "ledr_rd");
        peek(16'hFFFC, 16'h00CD, "ledg_rd");

        // Unmapped addresses and read-only registers
        peek(16'hFFFE, 16'hDEAD, "unmapped_fffe");
        check("iosel_fffe", 32'(IOSEL), 32'd1);
        peek(16'h0100, 16'hDEAD, "unmapped_0100");
        check("iosel_0100", 32'(IOSEL), 32'd0);
        store(16'hFFF0, 16'h0000);
        peek(16'hFFF0, 16'h000F, "key_ro");
        store(16'h0100, 16'h5555);
        check("hex_untouched", 32'(HEXOUT), 32'h1234);

        // Reset mid-debounce with TCNT=5: everything restarts
        KEY = 4'b1110;
        repeat (2) cyc();
        store(16'hFFF6, 16'h0005);
        cyc();
        peek(16'hFFF6, 16'h0005, "tcnt_pre_rst");
        RESET = 1'b1;
        peek(16'hFFF6, 16'h0000, "rst_view_tcnt");
        peek(16'hFFF8, 16'h0000, "rst_view_hex");
        cyc();
        RESET = 1'b0;
        peek(16'hFFF6, 16'h0000, "post_rst_tcnt");
        peek(16'hFFFA, 16'h0000, "post_rst_ledr");
        peek(16'hFFFC, 16'h0000, "post_rst_ledg");
        check("post_rst_hexout", 32'(HEXOUT), 32'h0);
        ADDR = 16'hFFF0;
        repeat (5) cyc();
        peek(16'hFFF0, 16'h000F, "deb_restart_early");
        cyc();
        peek(16'hFFF0, 16'h000E, "deb_restart_done");
        KEY = 4'hF;
        repeat (6) cyc();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(5) == 0) KEY = 4'($urandom);
            if ($urandom_range(5) == 0) SW = 10'($urandom);
            ADDR = addr_tbl[$urandom_range(9)];
            WE = ($urandom_range(2) == 0);
            WDATA = 16'($urandom);
            RESET = ($urandom_range(199) == 0);
            cyc();
        end
        RESET = 1'b0;
        WE = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
